// File: rtl/intc_pkg.sv
// intc_pkg: register addresses and field positions shared by the interrupt controller
package intc_pkg;
  localparam logic [2:0] INTC_PEND = 3'd0;
  localparam logic [2:0] INTC_MASK = 3'd1;
  localparam logic [2:0] INTC_MODE = 3'd2;
  localparam logic [2:0] INTC_VEC  = 3'd3;
  localparam logic [2:0] INTC_ISR  = 3'd4;
  localparam logic [2:0] INTC_SWI  = 3'd5;
  localparam int VEC_VALID_BIT = 7;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-set-bit encoder over 8 bits, idx is 0 when no bit is set
module intc_prio_enc (
  input  logic [7:0] i_bits,
  output logic       o_any,
  output logic [2:0] o_idx
);
  assign o_any = |i_bits;
  always_comb begin
    o_idx = 3'd0;
    for (int i = 7; i >= 0; i--) o_idx = i_bits[i] ? 3'(i) : o_idx;
  end
endmodule

// File: rtl/intc.sv
// intc: 8-source interrupt controller with mask, edge/level mode, fixed priority and nesting
module intc
  import intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            rw,
  input  logic            cs,
  input  logic [NSRC-1:0] src,
  output logic            irq
);
  logic [7:0] r_src_q, r_src_d, r_pend, r_mask, r_mode, r_isr;
  logic       r_irq, r_rd_d;
  logic [7:0] w_impl, w_below, w_elig, w_ack_bit, w_eoi_bit, w_swi, w_w1c, w_edge_next, w_level_next, w_vec;
  logic [2:0] w_elig_idx, w_isr_idx;
  logic       w_elig_any, w_isr_any, w_wr, w_rd, w_ack;
  assign w_impl = 8'((9'd1 << NSRC) - 9'd1);
  intc_prio_enc u_isr_enc (.i_bits(r_isr), .o_any(w_isr_any), .o_idx(w_isr_idx));
  assign w_below = w_isr_any ? 8'((9'd1 << w_isr_idx) - 9'd1) : 8'hff;
  assign w_elig = r_pend & r_mask & w_below;
  intc_prio_enc u_elig_enc (.i_bits(w_elig), .o_any(w_elig_any), .o_idx(w_elig_idx));
  assign w_wr = cs && !rw;
  assign w_rd = cs && rw && AD == INTC_VEC;
  assign w_ack = w_rd && !r_rd_d && w_elig_any;
  assign w_ack_bit = w_ack ? 8'd1 << w_elig_idx : 8'd0;
  assign w_eoi_bit = (w_wr && AD == INTC_ISR && w_isr_any) ? 8'd1 << w_isr_idx : 8'd0;
  assign w_swi = (w_wr && AD == INTC_SWI) ? DI : 8'd0;
  assign w_w1c = (w_wr && AD == INTC_PEND) ? DI : 8'd0;
  assign w_edge_next = (r_pend & ~w_w1c & ~w_ack_bit) | (r_src_q & ~r_src_d) | w_swi;
  assign w_level_next = r_src_q | w_swi;
  assign w_vec = (8'(w_elig_any) << VEC_VALID_BIT) | 8'(w_elig_idx);
  assign DO = AD == INTC_PEND ? r_pend :
              AD == INTC_MASK ? r_mask :
              AD == INTC_MODE ? r_mode :
              AD == INTC_VEC  ? w_vec  :
              AD == INTC_ISR  ? r_isr  : 8'h00;
  assign irq = r_irq;
  always_ff @(posedge clk)
    if (rst) begin
      r_src_q <= '0;
      r_src_d <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_mode  <= '0;
      r_isr   <= '0;
      r_irq   <= 1'b0;
      r_rd_d  <= 1'b0;
    end else begin
      r_src_q <= 8'(src) & w_impl;
      r_src_d <= r_src_q;
      r_pend  <= ((r_mode & w_edge_next) | (~r_mode & w_level_next)) & w_impl;
      r_mask  <= (w_wr && AD == INTC_MASK) ? DI & w_impl : r_mask;
      r_mode  <= (w_wr && AD == INTC_MODE) ? DI & w_impl : r_mode;
      r_isr   <= (r_isr | w_ack_bit) & ~w_eoi_bit;
      r_irq   <= w_elig_any;
      r_rd_d  <= w_rd;
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed plan with literal expectations plus randomized run against a behavioural model
module tb_intc;
  logic       clk = 1'b0, rst = 1'b1, rw = 1'b1, cs = 1'b0, irq;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'd0, src = 8'd0, DO;
  int n_cmp = 0, n_bad = 0;
  bit started = 1'b0;
  always #5 clk = ~clk;
  intc #(.NSRC(8)) dut (.clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .src(src), .irq(irq));
  logic [7:0] m_pend, m_mask, m_mode, m_isr, m_sq, m_sd;
  logic       m_irq, m_rdd;
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction
  function automatic logic [7:0] eligible();
    logic [7:0] e = 8'd0;
    for (int i = 0; i < 8; i++) if (i < lowest(m_isr)) e[i] = m_pend[i] & m_mask[i];
    return e;
  endfunction
  function automatic logic [7:0] m_do(input logic [2:0] a);
    int v = lowest(eligible());
    case (a)
      3'd0: return m_pend;
      3'd1: return m_mask;
      3'd2: return m_mode;
      3'd3: return (v < 8) ? (8'h80 | 8'(v)) : 8'h00;
      3'd4: return m_isr;
      default: return 8'h00;
    endcase
  endfunction
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin : mdl
    int li, v;
    logic [7:0] el, np;
    bit rd, ack, wr;
    if (rst) begin
      {m_pend, m_mask, m_mode, m_isr, m_sq, m_sd} = '0;
      m_irq = 1'b0;
      m_rdd = 1'b0;
      started = 1'b1;
    end else begin
      li = lowest(m_isr);
      el = eligible();
      v = lowest(el);
      wr = cs && !rw;
      rd = cs && rw && AD == 3'd3;
      ack = rd && !m_rdd && v < 8;
      for (int i = 0; i < 8; i++) begin
        if (m_mode[i]) begin
          np[i] = m_pend[i];
          if (wr && AD == 3'd0 && DI[i]) np[i] = 1'b0;
          if (ack && v == i) np[i] = 1'b0;
          if (m_sq[i] && !m_sd[i]) np[i] = 1'b1;
        end else np[i] = m_sq[i];
        if (wr && AD == 3'd5 && DI[i]) np[i] = 1'b1;
      end
      if (ack) m_isr[v] = 1'b1;
      if (wr && AD == 3'd4 && li < 8) m_isr[li] = 1'b0;
      if (wr && AD == 3'd1) m_mask = DI;
      if (wr && AD == 3'd2) m_mode = DI;
      m_irq = el != 8'd0;
      m_pend = np;
      m_sd = m_sq;
      m_sq = src;
      m_rdd = rd;
    end
    #2;
    if (started) begin
      check("model_irq", 8'(irq), 8'(m_irq));
      check("model_do", DO, m_do(AD));
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    step(1);
    cs = 1'b0; rw = 1'b1;
  endtask
  task automatic rdv();
    cs = 1'b1; rw = 1'b1; AD = 3'd3;
    step(1);
    cs = 1'b0;
  endtask
  task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string nm);
    cs = 1'b0; AD = a;
    #1;
    check(nm, DO, exp);
  endtask
  task automatic chk_irq(input logic exp, input string nm);
    check(nm, 8'(irq), 8'(exp));
  endtask
  initial begin
    step(2);
    rst = 1'b0;
    peek(3'd0, 8'h00, "rst_pend");
    peek(3'd1, 8'h00, "rst_mask");
    peek(3'd3, 8'h00, "rst_vec");
    chk_irq(1'b0, "rst_irq");
    wr(3'd1, 8'h01); wr(3'd2, 8'h01);
    src = 8'h01; step(1); src = 8'h00; step(1);
    chk_irq(1'b0, "edge_irq_lat1");
    peek(3'd0, 8'h01, "edge_pend");
    step(1);
    chk_irq(1'b1, "edge_irq_lat2");
    peek(3'd3, 8'h80, "edge_vec");
    rdv(); step(1);
    peek(3'd4, 8'h01, "edge_isr");
    peek(3'd0, 8'h00, "edge_pend_ack");
    chk_irq(1'b0, "edge_irq_fall");
    wr(3'd4, 8'h00);
    peek(3'd4, 8'h00, "edge_eoi");
    wr(3'd1, 8'h04); wr(3'd2, 8'h00);
    src = 8'h04; step(3);
    chk_irq(1'b1, "lvl_irq");
    peek(3'd3, 8'h82, "lvl_vec");
    rdv(); step(1);
    chk_irq(1'b0, "lvl_irq_isr");
    peek(3'd4, 8'h04, "lvl_isr");
    peek(3'd0, 8'h04, "lvl_pend_held");
    wr(3'd4, 8'h00);
    chk_irq(1'b0, "lvl_irq_eoi0");
    step(1);
    chk_irq(1'b1, "lvl_irq_reassert");
    src = 8'h00; step(2);
    peek(3'd0, 8'h00, "lvl_pend_drop");
    step(1);
    wr(3'd1, 8'h2a); wr(3'd2, 8'h2a);
    src = 8'h08; step(1); src = 8'h00; step(2);
    peek(3'd3, 8'h83, "nest_vec3");
    rdv();
    peek(3'd4, 8'h08, "nest_isr3");
    src = 8'h20; step(1); src = 8'h02; step(1); src = 8'h00; step(3);
    chk_irq(1'b1, "nest_irq1");
    peek(3'd3, 8'h81, "nest_vec1");
    rdv();
    peek(3'd4, 8'h0a, "nest_isr31");
    step(2);
    chk_irq(1'b0, "nest_blocked");
    wr(3'd4, 8'h00);
    peek(3'd4, 8'h08, "nest_eoi1");
    step(2);
    chk_irq(1'b0, "nest_still_blocked");
    peek(3'd0, 8'h20, "nest_pend5");
    wr(3'd4, 8'h00); step(1);
    chk_irq(1'b1, "nest_irq5");
    peek(3'd3, 8'h85, "nest_vec5");
    rdv(); wr(3'd4, 8'h00);
    wr(3'd1, 8'h00); wr(3'd2, 8'h20); wr(3'd5, 8'h20);
    peek(3'd0, 8'h20, "swi_pend");
    step(1);
    chk_irq(1'b0, "swi_masked");
    wr(3'd1, 8'h20); step(1);
    chk_irq(1'b1, "swi_unmasked");
    wr(3'd0, 8'h20);
    peek(3'd0, 8'h00, "swi_w1c");
    wr(3'd2, 8'h01); wr(3'd1, 8'h01);
    src = 8'h01; step(1); src = 8'h00;
    wr(3'd0, 8'h01);
    peek(3'd0, 8'h01, "coll_pend");
    cs = 1'b1; rw = 1'b1; AD = 3'd3; step(3); cs = 1'b0;
    peek(3'd4, 8'h01, "hold_isr");
    peek(3'd0, 8'h00, "hold_pend");
    wr(3'd4, 8'h00);
    wr(3'd2, 8'hff); wr(3'd1, 8'hff); wr(3'd5, 8'h02); rdv();
    wr(3'd5, 8'hff); rdv(); wr(3'd5, 8'hff);
    peek(3'd4, 8'h03, "pre_rst_isr");
    peek(3'd0, 8'hff, "pre_rst_pend");
    rst = 1'b1; step(1); rst = 1'b0;
    peek(3'd0, 8'h00, "mid_rst_pend");
    peek(3'd1, 8'h00, "mid_rst_mask");
    peek(3'd2, 8'h00, "mid_rst_mode");
    peek(3'd4, 8'h00, "mid_rst_isr");
    peek(3'd3, 8'h00, "mid_rst_vec");
    chk_irq(1'b0, "mid_rst_irq");
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom % 600) == 0;
      if (($urandom % 4) == 0) src = src ^ (8'($urandom) & 8'($urandom));
      cs = ($urandom % 3) != 0;
      rw = $urandom % 2;
      AD = 3'($urandom);
      DI = 8'($urandom);
      step(1);
    end
    cs = 1'b0; rst = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
